sram_axi_bridge: RTL
====================

// Module: sram_axi_bridge
// PURPOSE
//   Sits directly below the CPU core. Converts the core's two SRAM-like request ports into one AXI3 master:
//   inst port is read-only, data port is read/write (req/addr_ok/data_ok handshake).
//   Arbitrates the shared AR channel and steers R beats back by ID.
//   Single-beat transfers only; at most one read outstanding per port and one data write outstanding.
// PARAMETERS
//   INST_ID   4'd0  ARID used for instruction fetches
//   DATA_ID   4'd1  ARID/AWID used for data accesses
//   DATA_PRI  1     1: data read wins AR arbitration over inst read; 0: inst wins
// PORTS
//   clk               in   1   single clock
//   reset             in   1   asynchronous, active-high reset
//   inst_sram_req     in   1   fetch request, held until addr_ok
//   inst_sram_size    in   2   log2 bytes (0/1/2)
//   inst_sram_addr    in   32  fetch byte address
//   inst_sram_addr_ok out  1   request accepted this cycle
//   inst_sram_data_ok out  1   read data valid this cycle (1-cycle pulse)
//   inst_sram_rdata   out  32  fetched word
//   data_sram_req     in   1   data request, held until addr_ok
//   data_sram_wr      in   1   1 = store, 0 = load
//   data_sram_size    in   2   log2 bytes
//   data_sram_wstrb   in   4   byte enables for store
//   data_sram_addr    in   32  byte address
//   data_sram_wdata   in   32  store data
//   data_sram_addr_ok out  1   request accepted this cycle
//   data_sram_data_ok out  1   load data / store completion pulse
//   data_sram_rdata   out  32  load data
//   arid/araddr/arsize out 4/32/3  AR payload
//   arvalid in arready         AR handshake (out/in)
//   rid/rdata/rresp/rlast in 4/32/2/1  R payload
//   rvalid in, rready out      R handshake
//   awid/awaddr/awsize out 4/32/3  AW payload
//   awvalid out, awready in    AW handshake
//   wdata/wstrb/wlast out 32/4/1   W payload
//   wvalid out, wready in      W handshake
//   bid/bresp in 4/2, bvalid in, bready out  B channel
//   arlen/awlen=0, arburst/awburst=2'b01, lock=0, cache=0, prot=0, wid=DATA_ID: constant outputs
// BEHAVIOUR
//   Reset: arvalid, awvalid, wvalid, all *_addr_ok, all *_data_ok = 0; rready = bready = 1; FSMs IDLE; pending flags cleared.
//   Read FSM: IDLE -> AR (arvalid=1, payload registered) -> on arready&&arvalid -> IDLE.
//   Read accept in IDLE, one cycle (addr_ok = combinational pulse):
//     - Eligible port: req=1, no read pending on that port, and for data: wr=0, no write pending.
//     - Both eligible: DATA_PRI picks winner; loser's addr_ok stays 0.
//   arvalid rises the cycle after addr_ok and holds with stable payload until arready.
//   arsize = {1'b0, size}; araddr = request address unmodified.
//   Pending flag set at addr_ok; cleared on R handshake with matching rid.
//   R routing: rready tied 1. rvalid && rid==INST_ID -> inst_data_ok=1, inst_rdata=rdata (same cycle, combinational). Same for DATA_ID.
//   rvalid with an unknown rid or no pending flag is consumed and dropped.
//   Write FSM: W_IDLE -> W_REQ -> W_RESP -> W_IDLE.
//     - Accept in W_IDLE when data req && wr && no data read pending: addr_ok=1.
//     - Store read-after-write ordering: data loads are not accepted while any write is pending (W_REQ or W_RESP).
//     - W_REQ: awvalid and wvalid rise together next cycle.
//     - aw_done / w_done tracked independently: each valid drops after its own handshake; either order or simultaneous.
//     - Both done -> W_RESP. bvalid && bid==DATA_ID -> data_data_ok=1 for one cycle -> W_IDLE.
//   Simultaneous events:
//     - data read and data write are never both accepted in one cycle; the data port presents one request at a time.
//     - inst read may be accepted in the same cycle as a data write.
//     - data_ok for inst and data may pulse in the same cycle.
//   Reset mid-transaction clears all state immediately; in-flight AXI responses after reset are dropped.
//   Latency (zero-wait slave): read addr_ok -> arvalid +1 -> rvalid +1 -> data_ok same cycle; minimum 2 cycles.
// CONFIGURATION
//   BRIDGE_POSTED_WR_EN defined:
//     - data_sram_data_ok for a store pulses the cycle both AW and W have completed, not at B.
//     - W_RESP still blocks new writes and data loads until bvalid.
//     - bresp is ignored.
//   BRIDGE_POSTED_WR_EN undefined: store data_ok waits for B as described above.
// TESTING
//   T1 inst req addr=0x1C000000, arready=1, R after 1 cycle rid=0 rdata=0x02800C0C
//      -> addr_ok cycle0, arvalid cycle1 arid=0, inst data_ok+rdata cycle2.
//   T2 inst and data load same cycle, DATA_PRI=1
//      -> data addr_ok=1, inst addr_ok=0; data AR issued first, inst accepted next IDLE cycle; out-of-order R (rid 0 before 1) routed correctly.
//   T3 store addr=0x100 wstrb=4'b0011 wdata=0xABCD1234, awready delayed 3 cycles, wready immediate
//      -> wvalid drops after 1 cycle, awvalid held 3 cycles; data_ok only on bvalid.
//   T4 load to 0x100 issued while store in W_RESP
//      -> load addr_ok held 0 until the cycle after bvalid; AR payload 0x100 afterwards.
//   T5 async reset asserted while arvalid=1 awaiting arready
//      -> arvalid=0 immediately; a later rvalid rid=1 gives no data_ok.
//   T6 BRIDGE_POSTED_WR_EN defined, store with bvalid delayed 5 cycles
//      -> data_ok in the cycle after AW/W complete; the next load is stalled until B.

Source files
------------

// File: rtl/sram_axi_bridge.sv
// SRAM-like inst (read-only) and data (read/write) ports to one AXI3 master, single-beat only.
// Define BRIDGE_POSTED_WR_EN to acknowledge stores once AW and W complete instead of at B.
module sram_axi_bridge #(
  parameter logic [3:0] INST_ID  = 4'd0,
  parameter logic [3:0] DATA_ID  = 4'd1,
  parameter bit         DATA_PRI = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_req,
  input  logic [1:0]  inst_sram_size,
  input  logic [31:0] inst_sram_addr,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic {StRdIdle, StRdAr} rd_state_e;
  typedef enum logic [1:0] {StWrIdle, StWrReq, StWrResp} wr_state_e;

  rd_state_e   r_rd_state;
  wr_state_e   r_wr_state;
  logic        r_inst_pend, r_data_pend;
  logic        r_arvalid;
  logic [3:0]  r_arid;
  logic [31:0] r_araddr;
  logic [2:0]  r_arsize;
  logic        r_awvalid, r_wvalid, r_aw_done, r_w_done;
  logic [31:0] r_awaddr, r_wdata;
  logic [2:0]  r_awsize;
  logic [3:0]  r_wstrb;

  logic w_inst_elig, w_data_rd_elig, w_inst_acc, w_data_rd_acc, w_data_wr_acc;
  logic w_r_inst, w_r_data, w_b_done, w_aw_fin, w_w_fin, w_wr_ok;
  logic w_unused;

  // Data loads wait for any write in flight so a load never overtakes an earlier store.
  always_comb begin
    w_inst_elig    = inst_sram_req && !r_inst_pend;
    w_data_rd_elig = data_sram_req && !data_sram_wr && !r_data_pend && (r_wr_state == StWrIdle);
    w_inst_acc     = !reset && (r_rd_state == StRdIdle) && w_inst_elig &&
                     (!DATA_PRI || !w_data_rd_elig);
    w_data_rd_acc  = !reset && (r_rd_state == StRdIdle) && w_data_rd_elig &&
                     (DATA_PRI || !w_inst_elig);
    w_data_wr_acc  = !reset && (r_wr_state == StWrIdle) && data_sram_req && data_sram_wr &&
                     !r_data_pend;
    w_r_inst       = rvalid && (rid == INST_ID) && r_inst_pend;
    w_r_data       = rvalid && (rid == DATA_ID) && r_data_pend;
    w_b_done       = (r_wr_state == StWrResp) && bvalid && (bid == DATA_ID);
    w_aw_fin       = r_aw_done || (r_awvalid && awready);
    w_w_fin        = r_w_done || (r_wvalid && wready);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_state <= StRdIdle;
      r_arvalid  <= 1'b0;
      r_arid     <= 4'd0;
      r_araddr   <= 32'd0;
      r_arsize   <= 3'd0;
    end else begin
      case (r_rd_state)
        StRdIdle: begin
          if (w_inst_acc) begin
            r_rd_state <= StRdAr;
            r_arvalid  <= 1'b1;
            r_arid     <= INST_ID;
            r_araddr   <= inst_sram_addr;
            r_arsize   <= {1'b0, inst_sram_size};
          end else if (w_data_rd_acc) begin
            r_rd_state <= StRdAr;
            r_arvalid  <= 1'b1;
            r_arid     <= DATA_ID;
            r_araddr   <= data_sram_addr;
            r_arsize   <= {1'b0, data_sram_size};
          end
        end
        StRdAr: begin
          if (arready) begin
            r_rd_state <= StRdIdle;
            r_arvalid  <= 1'b0;
          end
        end
        default: r_rd_state <= StRdIdle;
      endcase
    end
  end

  // Set at acceptance and cleared by the matching R beat; the two never coincide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_inst_pend <= 1'b0;
      r_data_pend <= 1'b0;
    end else begin
      if (w_inst_acc)         r_inst_pend <= 1'b1;
      else if (w_r_inst)      r_inst_pend <= 1'b0;
      if (w_data_rd_acc)      r_data_pend <= 1'b1;
      else if (w_r_data)      r_data_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_state <= StWrIdle;
      r_awvalid  <= 1'b0;
      r_wvalid   <= 1'b0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
      r_awaddr   <= 32'd0;
      r_awsize   <= 3'd0;
      r_wdata    <= 32'd0;
      r_wstrb    <= 4'd0;
    end else begin
      case (r_wr_state)
        StWrIdle: begin
          if (w_data_wr_acc) begin
            r_wr_state <= StWrReq;
            r_awvalid  <= 1'b1;
            r_wvalid   <= 1'b1;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
            r_awaddr   <= data_sram_addr;
            r_awsize   <= {1'b0, data_sram_size};
            r_wdata    <= data_sram_wdata;
            r_wstrb    <= data_sram_wstrb;
          end
        end
        StWrReq: begin
          if (r_awvalid && awready) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (r_wvalid && wready) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
          end
          if (w_aw_fin && w_w_fin) r_wr_state <= StWrResp;
        end
        StWrResp: begin
          if (w_b_done) r_wr_state <= StWrIdle;
        end
        default: r_wr_state <= StWrIdle;
      endcase
    end
  end

`ifdef BRIDGE_POSTED_WR_EN
  logic r_wr_ok;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_wr_ok <= 1'b0;
    else       r_wr_ok <= (r_wr_state == StWrReq) && w_aw_fin && w_w_fin;
  end
  assign w_wr_ok = r_wr_ok;
`else
  assign w_wr_ok = w_b_done;
`endif

  assign inst_sram_addr_ok = w_inst_acc;
  assign inst_sram_data_ok = w_r_inst;
  assign inst_sram_rdata   = rdata;
  assign data_sram_addr_ok = w_data_rd_acc || w_data_wr_acc;
  assign data_sram_data_ok = w_r_data || w_wr_ok;
  assign data_sram_rdata   = rdata;

  assign arid    = r_arid;
  assign araddr  = r_araddr;
  assign arlen   = 4'd0;
  assign arsize  = r_arsize;
  assign arburst = 2'b01;
  assign arlock  = 2'd0;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign arvalid = r_arvalid;
  assign rready  = 1'b1;
  assign awid    = DATA_ID;
  assign awaddr  = r_awaddr;
  assign awlen   = 4'd0;
  assign awsize  = r_awsize;
  assign awburst = 2'b01;
  assign awlock  = 2'd0;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;
  assign awvalid = r_awvalid;
  assign wid     = DATA_ID;
  assign wdata   = r_wdata;
  assign wstrb   = r_wstrb;
  assign wlast   = 1'b1;
  assign wvalid  = r_wvalid;
  assign bready  = 1'b1;

  assign w_unused = ^{rresp, rlast, bresp};

endmodule
